// File: rtl/line_fill_buffer_pkg.sv
// Shared types for the line fill buffer and the cache datapath that reuses its word mux.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [15:0] lc3b_mem_addr;

    localparam int LFB_LINE_BITS = 128;
    localparam int OFF_BITS      = $clog2(LFB_LINE_BITS / 8);

    typedef logic [LFB_LINE_BITS-1:0] mem_bus;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Clears the within-line byte offset of an address.
    function automatic lc3b_mem_addr line_align(input lc3b_mem_addr addr, input int off_bits);
        lc3b_mem_addr mask;
        mask = (lc3b_mem_addr'(1) << off_bits) - lc3b_mem_addr'(1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/line_fill_buffer_word_select.sv
// Combinational word mux: picks word idx out of a full line (word 0 in the low bits).
module line_word_select
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 16,
    localparam int IDX_BITS = $clog2(LINE_BITS / WORD_BITS)
) (
    input  logic [LINE_BITS-1:0] line,
    input  logic [IDX_BITS-1:0]  idx,
    output logic [WORD_BITS-1:0] word
);

    assign word = line[idx*WORD_BITS +: WORD_BITS];

endmodule

// File: rtl/line_fill_buffer.sv
// One-line fill buffer: bursts a line in beat-by-beat and serves word reads
// as soon as the beat holding the word has landed.
//
//   state | meaning
//   IDLE  | no burst outstanding; held line (if any) is readable
//   FILL  | burst in progress; mem_read held, beats land at beat_cnt
module line_fill_buffer
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 128,
    parameter int BEAT_BITS = 32,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fill_req,
    input  lc3b_mem_addr         fill_addr,
    input  logic                 invalidate,
    output logic                 mem_read,
    output lc3b_mem_addr         mem_address,
    input  logic                 mem_resp,
    input  logic [BEAT_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 line_valid,
    output lc3b_mem_addr         line_tag,
    output logic [LINE_BITS-1:0] line_data,
    input  lc3b_mem_addr         rd_addr,
    output logic                 rd_hit,
    output logic [WORD_BITS-1:0] rd_word
);

    localparam int BEATS     = LINE_BITS / BEAT_BITS;
    localparam int LINE_OFF  = $clog2(LINE_BITS / 8);
    localparam int BEAT_LSB  = $clog2(BEAT_BITS / 8);
    localparam int WORD_LSB  = $clog2(WORD_BITS / 8);
    localparam int CNT_BITS  = $clog2(BEATS);
    localparam int WIDX_BITS = $clog2(LINE_BITS / WORD_BITS);

    localparam lc3b_mem_addr        BEAT_BYTES = lc3b_mem_addr'(BEAT_BITS / 8);
    localparam logic [CNT_BITS-1:0] LAST_BEAT  = CNT_BITS'(BEATS - 1);

    fill_state_t          state, state_next;
    logic [CNT_BITS-1:0]  beat_cnt;
    logic [BEATS-1:0]     beat_valid;
    logic                 pend_inv;
    logic                 start_fill, beat_take, last_take, drop;
    logic [CNT_BITS-1:0]  rd_beat;
    logic [WIDX_BITS-1:0] rd_widx;

    always_comb begin
        state_next = state;
        start_fill = 1'b0;
        beat_take  = 1'b0;
        last_take  = 1'b0;
        case (state)
            IDLE: begin
                if (fill_req) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (mem_resp) begin
                    beat_take = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        last_take  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An invalidate on the final beat counts just like one seen earlier in the burst.
    assign drop = pend_inv | invalidate;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read    <= 1'b0;
            busy        <= 1'b0;
            mem_address <= '0;
            line_tag    <= '0;
            line_data   <= '0;
            line_valid  <= 1'b0;
            beat_valid  <= '0;
            beat_cnt    <= '0;
            pend_inv    <= 1'b0;
        end else begin
            mem_read <= (state_next == FILL);
            busy     <= (state_next == FILL);

            if (start_fill) begin
                line_tag    <= line_align(fill_addr, LINE_OFF);
                mem_address <= line_align(fill_addr, LINE_OFF);
                beat_valid  <= '0;
                line_valid  <= 1'b0;
                beat_cnt    <= '0;
                pend_inv    <= 1'b0;
            end else if (state == IDLE && invalidate) begin
                line_valid <= 1'b0;
                beat_valid <= '0;
            end

            if (state == FILL && invalidate) pend_inv <= 1'b1;

            if (beat_take) begin
                line_data[beat_cnt*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
                beat_cnt    <= beat_cnt + 1'b1;
                mem_address <= mem_address + BEAT_BYTES;
                if (last_take) begin
                    mem_address <= line_tag;
                    line_valid  <= ~drop;
                    beat_valid  <= drop ? '0 : '1;
                    pend_inv    <= 1'b0;
                end else begin
                    beat_valid[beat_cnt] <= 1'b1;
                end
            end
        end
    end

    assign rd_beat = rd_addr[LINE_OFF-1:BEAT_LSB];
    assign rd_widx = rd_addr[LINE_OFF-1:WORD_LSB];
    assign rd_hit  = (line_align(rd_addr, LINE_OFF) == line_tag) && beat_valid[rd_beat];

    line_word_select #(
        .LINE_BITS(LINE_BITS),
        .WORD_BITS(WORD_BITS)
    ) u_word_select (
        .line(line_data),
        .idx (rd_widx),
        .word(rd_word)
    );

endmodule

// File: tb/tb_line_fill_buffer.sv
// Randomized + directed bench for line_fill_buffer against a beat-array reference model.
module tb_line_fill_buffer;

    logic         clk = 1'b0;
    logic         rst, fill_req, invalidate, mem_resp;
    logic [15:0]  fill_addr, rd_addr, mem_address, line_tag;
    logic [31:0]  mem_rdata;
    logic         mem_read, busy, line_valid, rd_hit;
    logic [127:0] line_data;
    logic [15:0]  rd_word;

    logic         w_fill_req, w_mem_resp, w_mem_read, w_busy, w_line_valid, w_rd_hit;
    logic [15:0]  w_fill_addr, w_rd_addr, w_mem_address, w_line_tag, w_rd_word;
    logic [63:0]  w_mem_rdata;
    logic [255:0] w_line_data;

    always #5 clk = ~clk;

    line_fill_buffer #(.LINE_BITS(128), .BEAT_BITS(32), .WORD_BITS(16)) dut (
        .clk(clk), .rst(rst), .fill_req(fill_req), .fill_addr(fill_addr),
        .invalidate(invalidate), .mem_read(mem_read), .mem_address(mem_address),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy), .line_valid(line_valid),
        .line_tag(line_tag), .line_data(line_data), .rd_addr(rd_addr), .rd_hit(rd_hit),
        .rd_word(rd_word)
    );

    line_fill_buffer #(.LINE_BITS(256), .BEAT_BITS(64), .WORD_BITS(16)) dut_w (
        .clk(clk), .rst(rst), .fill_req(w_fill_req), .fill_addr(w_fill_addr),
        .invalidate(1'b0), .mem_read(w_mem_read), .mem_address(w_mem_address),
        .mem_resp(w_mem_resp), .mem_rdata(w_mem_rdata), .busy(w_busy),
        .line_valid(w_line_valid), .line_tag(w_line_tag), .line_data(w_line_data),
        .rd_addr(w_rd_addr), .rd_hit(w_rd_hit), .rd_word(w_rd_word)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the line as four 32-bit beats with a present flag each.
    logic [15:0] m_tag;
    logic [31:0] m_data [4];
    bit          m_valid [4];
    bit          m_lv, m_busy, m_pend;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tag = 16'h0; m_lv = 0; m_busy = 0; m_pend = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin m_data[i] = 32'h0; m_valid[i] = 0; end
    endtask

    task automatic probe(input logic [15:0] a);
        int b;
        bit h;
        rd_addr = a;
        #1;
        b = int'((a >> 2) & 16'h3);
        h = ((a & 16'hFFF0) == m_tag) && m_valid[b];
        chk("rd_hit", rd_hit, h);
        if (h) chk("rd_word", rd_word, 16'(m_data[b] >> (16 * int'((a >> 1) & 16'h1))));
    endtask

    task automatic step(input logic r, input logic fr, input logic inv, input logic resp,
                        input logic [15:0] fa, input logic [31:0] rdat);
        bit drop;
        rst = r; fill_req = fr; invalidate = inv; mem_resp = resp;
        fill_addr = fa; mem_rdata = rdat;
        if (r) model_reset();
        else if (!m_busy) begin
            if (fr) begin
                m_tag = fa & 16'hFFF0; m_lv = 0; m_cnt = 0; m_pend = 0; m_busy = 1;
                for (int i = 0; i < 4; i++) m_valid[i] = 0;
            end else if (inv) begin
                m_lv = 0;
                for (int i = 0; i < 4; i++) m_valid[i] = 0;
            end
        end else begin
            drop = m_pend | inv;
            if (inv) m_pend = 1;
            if (resp) begin
                m_data[m_cnt] = rdat;
                m_valid[m_cnt] = 1;
                if (m_cnt == 3) begin
                    m_busy = 0; m_lv = !drop; m_cnt = 0; m_pend = 0;
                    if (drop) for (int i = 0; i < 4; i++) m_valid[i] = 0;
                end else m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("mem_read", mem_read, m_busy);
        chk("busy", busy, m_busy);
        chk("line_valid", line_valid, m_lv);
        chk("line_tag", line_tag, m_tag);
        if (m_busy) chk("mem_address", mem_address, 16'(m_tag + 16'(4 * m_cnt)));
        if ($urandom_range(0, 1) == 1) probe(m_tag | 16'($urandom_range(0, 15)));
        else probe(16'($urandom));
    endtask

    logic [63:0] w_beats [4];
    logic [63:0] tmp;

    initial begin
        model_reset();
        rst = 1; fill_req = 0; invalidate = 0; mem_resp = 0;
        fill_addr = 0; mem_rdata = 0; rd_addr = 0;
        w_fill_req = 0; w_fill_addr = 0; w_mem_resp = 0; w_mem_rdata = 0; w_rd_addr = 0;

        // Reset
        step(1, 0, 0, 0, 16'h0, 32'h0);
        step(1, 0, 0, 0, 16'h0, 32'h0);
        rd_addr = 16'h0000; #1;
        chk("reset_rd_hit", rd_hit, 1'b0);
        chk("reset_mem_read", mem_read, 1'b0);

        // Basic fill with early hit and a stalled memory
        step(0, 1, 0, 0, 16'h1234, 32'h0);
        chk("tag_1230", line_tag, 16'h1230);
        chk("addr_beat0", mem_address, 16'h1230);
        step(0, 0, 0, 1, 16'h0, 32'h11112222);
        chk("addr_beat1", mem_address, 16'h1234);
        step(0, 0, 0, 1, 16'h0, 32'hBEEFCAFE);
        rd_addr = 16'h1236; #1;
        chk("early_hit", rd_hit, 1'b1);
        chk("early_word", rd_word, 16'hBEEF);
        rd_addr = 16'h123A; #1;
        chk("early_miss", rd_hit, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 16'h0, $urandom);
            chk("stall_addr", mem_address, 16'h1238);
            chk("stall_read", mem_read, 1'b1);
        end
        step(0, 0, 0, 1, 16'h0, 32'h33334444);
        chk("addr_beat3", mem_address, 16'h123C);
        step(0, 0, 0, 1, 16'h0, 32'h55556666);
        chk("lv_after_fill", line_valid, 1'b1);
        chk("busy_after_fill", busy, 1'b0);
        for (int i = 0; i < 8; i++) probe(16'h1230 + 16'(2 * i));

        // Invalidate mid-fill plus an ignored second request
        step(0, 1, 0, 0, 16'h1230, 32'h0);
        step(0, 0, 0, 1, 16'h0, $urandom);
        step(0, 0, 0, 1, 16'h0, $urandom);
        step(0, 0, 1, 1, 16'h0, $urandom);
        step(0, 1, 0, 0, 16'h4000, 32'h0);
        step(0, 0, 0, 1, 16'h0, $urandom);
        chk("inv_lv", line_valid, 1'b0);
        chk("inv_tag", line_tag, 16'h1230);
        step(0, 0, 0, 0, 16'h0, 32'h0);
        chk("no_queue_busy", busy, 1'b0);
        rd_addr = 16'h1232; #1;
        chk("inv_rd_hit", rd_hit, 1'b0);

        // Reset mid-fill, stray response, then a clean refill
        step(0, 1, 0, 0, 16'h1230, 32'h0);
        step(0, 0, 0, 1, 16'h0, $urandom);
        step(0, 0, 0, 1, 16'h0, $urandom);
        step(1, 0, 0, 0, 16'h0, 32'h0);
        chk("rst_mem_read", mem_read, 1'b0);
        rd_addr = 16'h0000; #1;
        chk("rst_rd_hit", rd_hit, 1'b0);
        step(0, 0, 0, 1, 16'h0, 32'hDEADBEEF);
        chk("stray_busy", busy, 1'b0);
        chk("stray_lv", line_valid, 1'b0);
        step(0, 1, 0, 0, 16'h2000, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h0, $urandom);
        chk("refill_lv", line_valid, 1'b1);
        chk("refill_tag", line_tag, 16'h2000);

        // Fill request and invalidate together in IDLE: fill wins
        step(0, 1, 1, 0, 16'h3008, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h0, $urandom);
        chk("fill_inv_lv", line_valid, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 16'($urandom), $urandom);

        // Wide-line variant: word index mapping over a 256-bit line
        step(0, 0, 0, 0, 16'h0, 32'h0);
        w_fill_addr = 16'h053A; w_fill_req = 1;
        @(posedge clk); #1;
        w_fill_req = 0;
        chk("w_tag", w_line_tag, 16'h0520);
        chk("w_mem_read", w_mem_read, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("w_mem_address", w_mem_address, 16'h0520 + 16'(8 * i));
            w_beats[i] = {$urandom, $urandom};
            w_mem_resp = 1; w_mem_rdata = w_beats[i];
            @(posedge clk); #1;
            w_mem_resp = 0;
        end
        chk("w_line_valid", w_line_valid, 1'b1);
        chk("w_busy", w_busy, 1'b0);
        for (int w = 0; w < 16; w++) begin
            tmp = w_beats[w / 4];
            w_rd_addr = 16'h0520 + 16'(2 * w); #1;
            chk("w_rd_hit", w_rd_hit, 1'b1);
            chk("w_rd_word", w_rd_word, 16'(tmp >> (16 * (w % 4))));
            w_rd_addr = 16'h0521 + 16'(2 * w); #1;
            chk("w_rd_word_odd", w_rd_word, 16'(tmp >> (16 * (w % 4))));
        end
        w_rd_addr = 16'h0540; #1;
        chk("w_rd_miss", w_rd_hit, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
